// File: rtl/octet_loader_if.sv
// octet_loader_if: beat stream, bOctet operand/strobe buses and result stream
// of one octet_loader. The master side is the environment (DMA, bOctet,
// result consumer); the slave side is the loader itself.
interface octet_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_kind;
  logic [63:0]  in_data;
  logic [255:0] weight_data;
  logic [63:0]  weight_sign;
  logic [63:0]  weight_sel_level0;
  logic [127:0] weight_sel_level1;
  logic [95:0]  shift_offset;
  logic [255:0] activation_out;
  logic [127:0] psum_out;
  logic         weight_update;
  logic         activation_update;
  logic         psum_update;
  logic [127:0] result_in;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         err_abort;

  modport master (
    output in_valid, in_kind, in_data, result_in, res_ready,
    input  in_ready, weight_data, weight_sign, weight_sel_level0,
           weight_sel_level1, shift_offset, activation_out, psum_out,
           weight_update, activation_update, psum_update,
           res_valid, res_data, err_abort
  );

  modport slave (
    input  in_valid, in_kind, in_data, result_in, res_ready,
    output in_ready, weight_data, weight_sign, weight_sel_level0,
           weight_sel_level1, shift_offset, activation_out, psum_out,
           weight_update, activation_update, psum_update,
           res_valid, res_data, err_abort
  );
endinterface

// File: rtl/octet_loader.sv
// octet_loader: assembles typed 64-bit beats into weight / activation / psum
// bundles for one bOctet, strobes each completed bundle, waits RESULT_LAT
// cycles after the psum strobe and holds the captured result for downstream.
// Optional feature macro: OCTET_PSUM_ZERO_EN (kind-3 beat zeroes psum and
// starts a compute instead of being dropped as an error).
module octet_loader #(
  parameter int RESULT_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  octet_loader_if.slave bus
);
  typedef enum logic [1:0] {LOAD = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [1:0] KIND_W = 2'd0;
  localparam logic [1:0] KIND_A = 2'd1;
  localparam logic [1:0] KIND_P = 2'd2;
  localparam logic [3:0] LAT_INIT = 4'(RESULT_LAT);

  state_t       state_reg;
  logic [1:0]   kind_reg;
  logic [3:0]   beat_cnt_reg;
  logic [3:0]   lat_cnt_reg;

  logic [255:0] weight_data_reg;
  logic [63:0]  weight_sign_reg;
  logic [63:0]  weight_sel0_reg;
  logic [127:0] weight_sel1_reg;
  logic [95:0]  shift_offset_reg;
  logic [255:0] activation_reg;
  logic [127:0] psum_reg;
  logic         weight_update_reg;
  logic         activation_update_reg;
  logic         psum_update_reg;
  logic         res_valid_reg;
  logic [127:0] res_data_reg;
  logic         err_abort_reg;

  logic         accept;
  logic         kind_change;
  logic [3:0]   slot;
  logic         last_w;
  logic         last_a;
  logic         last_p;
  logic [607:0] w_flat;
  logic [255:0] a_flat;
  logic [127:0] p_flat;
  logic [63:0]  p_slot_reg;

  // A partial bundle of another kind is abandoned; the new beat restarts at slot 0.
  assign accept      = bus.in_valid && (state_reg == LOAD);
  assign kind_change = accept && (beat_cnt_reg != 4'd0) && (bus.in_kind != kind_reg);
  assign slot        = kind_change ? 4'd0 : beat_cnt_reg;
  assign last_w      = (bus.in_kind == KIND_W) && (slot == 4'd9);
  assign last_a      = (bus.in_kind == KIND_A) && (slot == 4'd3);
  assign last_p      = (bus.in_kind == KIND_P) && (slot == 4'd1);

  // The final beat of each bundle comes straight from in_data, so only the
  // earlier slots need shadow storage. Beat 9 of a weight bundle is 32 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_wslot
      logic [63:0] slot_reg;
      assign w_flat[64*gi +: 64] = slot_reg;
      // Capture a non-final weight beat into its shadow slot.
      always_ff @(posedge clk) begin
        if (accept && (bus.in_kind == KIND_W) && !last_w && (slot == 4'(gi)))
          slot_reg <= bus.in_data;
      end
    end
    for (gi = 0; gi < 3; gi++) begin : g_aslot
      logic [63:0] slot_reg;
      assign a_flat[64*gi +: 64] = slot_reg;
      // Capture a non-final activation beat into its shadow slot.
      always_ff @(posedge clk) begin
        if (accept && (bus.in_kind == KIND_A) && !last_a && (slot == 4'(gi)))
          slot_reg <= bus.in_data;
      end
    end
  endgenerate

  assign w_flat[607:576] = bus.in_data[31:0];
  assign a_flat[255:192] = bus.in_data;
  assign p_flat          = {bus.in_data, p_slot_reg};

  // Capture psum beat 0 into its shadow slot.
  always_ff @(posedge clk) begin
    if (accept && (bus.in_kind == KIND_P) && !last_p)
      p_slot_reg <= bus.in_data;
  end

  // Sequencer: bundle assembly, strobes, latency countdown and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg             <= LOAD;
      kind_reg              <= KIND_W;
      beat_cnt_reg          <= 4'd0;
      lat_cnt_reg           <= 4'd0;
      weight_data_reg       <= '0;
      weight_sign_reg       <= '0;
      weight_sel0_reg       <= '0;
      weight_sel1_reg       <= '0;
      shift_offset_reg      <= '0;
      activation_reg        <= '0;
      psum_reg              <= '0;
      weight_update_reg     <= 1'b0;
      activation_update_reg <= 1'b0;
      psum_update_reg       <= 1'b0;
      res_valid_reg         <= 1'b0;
      res_data_reg          <= '0;
      err_abort_reg         <= 1'b0;
    end else begin
      weight_update_reg     <= 1'b0;
      activation_update_reg <= 1'b0;
      psum_update_reg       <= 1'b0;
      err_abort_reg         <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            err_abort_reg <= kind_change;
            kind_reg      <= bus.in_kind;
            beat_cnt_reg  <= slot + 4'd1;
            case (bus.in_kind)
              KIND_W: begin
                if (last_w) begin
                  weight_data_reg   <= w_flat[255:0];
                  weight_sign_reg   <= w_flat[319:256];
                  weight_sel0_reg   <= w_flat[383:320];
                  weight_sel1_reg   <= w_flat[511:384];
                  shift_offset_reg  <= w_flat[607:512];
                  weight_update_reg <= 1'b1;
                  beat_cnt_reg      <= 4'd0;
                end
              end
              KIND_A: begin
                if (last_a) begin
                  activation_reg        <= a_flat;
                  activation_update_reg <= 1'b1;
                  beat_cnt_reg          <= 4'd0;
                end
              end
              KIND_P: begin
                if (last_p) begin
                  psum_reg        <= p_flat;
                  psum_update_reg <= 1'b1;
                  beat_cnt_reg    <= 4'd0;
                  lat_cnt_reg     <= LAT_INIT;
                  state_reg       <= WAIT;
                end
              end
              default: begin
`ifdef OCTET_PSUM_ZERO_EN
                // Psum-zero: behaves like a completed all-zero psum bundle.
                psum_reg        <= '0;
                psum_update_reg <= 1'b1;
                beat_cnt_reg    <= 4'd0;
                lat_cnt_reg     <= LAT_INIT;
                state_reg       <= WAIT;
`else
                // Unsupported kind: drop it, flagging one abort even if a
                // partial bundle is discarded at the same time.
                err_abort_reg <= 1'b1;
                beat_cnt_reg  <= 4'd0;
`endif
              end
            endcase
          end
        end
        WAIT: begin
          if (lat_cnt_reg == 4'd1) begin
            res_data_reg  <= bus.result_in;
            res_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign bus.in_ready          = (state_reg == LOAD);
  assign bus.weight_data       = weight_data_reg;
  assign bus.weight_sign       = weight_sign_reg;
  assign bus.weight_sel_level0 = weight_sel0_reg;
  assign bus.weight_sel_level1 = weight_sel1_reg;
  assign bus.shift_offset      = shift_offset_reg;
  assign bus.activation_out    = activation_reg;
  assign bus.psum_out          = psum_reg;
  assign bus.weight_update     = weight_update_reg;
  assign bus.activation_update = activation_update_reg;
  assign bus.psum_update       = psum_update_reg;
  assign bus.res_valid         = res_valid_reg;
  assign bus.res_data          = res_data_reg;
  assign bus.err_abort         = err_abort_reg;
endmodule

// File: tb/tb_octet_loader.sv
// tb_octet_loader: directed sequence for octet_loader (RESULT_LAT=2) with a
// scoreboard of expected bundles/results checked when the DUT strobes them.
module tb_octet_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int abort_pending = 0;

  logic [607:0] wq [$];
  logic [255:0] aq [$];
  logic [127:0] pq [$];
  logic [127:0] rq [$];
  logic [607:0] wexp_m;
  logic [255:0] aexp_m;
  logic [127:0] pexp_m;
  logic [127:0] rexp_m;

  octet_loader_if bus ();

  octet_loader #(.RESULT_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [63:0] d);
    bus.in_valid = 1'b1;
    bus.in_kind  = k;
    bus.in_data  = d;
    chk("in_ready_at_beat", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every strobe / result handshake pops and compares one entry.
  always @(negedge clk) begin
    if (bus.weight_update) begin
      checks++;
      assert (wq.size() != 0) else begin
        failures++;
        $error("FAIL weight_update_unexpected observed=1 expected=0");
      end
      if (wq.size() != 0) begin
        wexp_m = wq.pop_front();
        checks++;
        assert ({bus.shift_offset, bus.weight_sel_level1, bus.weight_sel_level0,
                 bus.weight_sign, bus.weight_data} === wexp_m) else begin
          failures++;
          $error("FAIL weight_bundle observed=%0h expected=%0h",
                 {bus.shift_offset, bus.weight_sel_level1, bus.weight_sel_level0,
                  bus.weight_sign, bus.weight_data}, wexp_m);
        end
      end
    end
    if (bus.activation_update) begin
      checks++;
      assert (aq.size() != 0) else begin
        failures++;
        $error("FAIL activation_update_unexpected observed=1 expected=0");
      end
      if (aq.size() != 0) begin
        aexp_m = aq.pop_front();
        checks++;
        assert (bus.activation_out === aexp_m) else begin
          failures++;
          $error("FAIL activation_bundle observed=%0h expected=%0h", bus.activation_out, aexp_m);
        end
      end
    end
    if (bus.psum_update) begin
      checks++;
      assert (pq.size() != 0) else begin
        failures++;
        $error("FAIL psum_update_unexpected observed=1 expected=0");
      end
      if (pq.size() != 0) begin
        pexp_m = pq.pop_front();
        checks++;
        assert (bus.psum_out === pexp_m) else begin
          failures++;
          $error("FAIL psum_bundle observed=%0h expected=%0h", bus.psum_out, pexp_m);
        end
      end
    end
    if (bus.res_valid && bus.res_ready) begin
      checks++;
      assert (rq.size() != 0) else begin
        failures++;
        $error("FAIL result_unexpected observed=1 expected=0");
      end
      if (rq.size() != 0) begin
        rexp_m = rq.pop_front();
        checks++;
        assert (bus.res_data === rexp_m) else begin
          failures++;
          $error("FAIL result_data observed=%0h expected=%0h", bus.res_data, rexp_m);
        end
      end
    end
    if (bus.err_abort) begin
      checks++;
      assert (abort_pending > 0) else begin
        failures++;
        $error("FAIL err_abort_unexpected observed=1 expected=0");
      end
      if (abort_pending > 0) abort_pending--;
    end
  end

  initial begin
    logic [607:0] wflat;
    logic [255:0] aflat;
    logic [63:0]  beat_v;
    logic [63:0]  p0;
    logic [63:0]  p1;
    logic [127:0] rv;
    logic [127:0] p_last;

    bus.in_valid  = 1'b0;
    bus.in_kind   = 2'd0;
    bus.in_data   = '0;
    bus.result_in = '0;
    bus.res_ready = 1'b0;
    p_last        = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready_after", bus.in_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_err_abort", bus.err_abort, 0);
    chk("rst_weight_data", bus.weight_data, 0);
    chk("rst_shift_offset", bus.shift_offset, 0);
    chk("rst_activation", bus.activation_out, 0);
    chk("rst_psum", bus.psum_out, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_strobes", {bus.weight_update, bus.activation_update, bus.psum_update}, 0);

    // Weight load, beat i carries value i
    wflat = '0;
    for (int i = 0; i < 9; i++) wflat[64*i +: 64] = 64'(i);
    wflat[607:576] = 32'd9;
    wq.push_back(wflat);
    for (int i = 0; i < 10; i++) begin
      send(2'd0, 64'(i));
      if (i == 8) chk("weight_update_early", bus.weight_update, 0);
    end
    chk("weight_update_pulse", bus.weight_update, 1);
    chk("weight_data_lo", bus.weight_data[63:0], 0);
    chk("weight_sign", bus.weight_sign, 64'h4);
    chk("shift_offset_lo", bus.shift_offset[31:0], 32'h8);
    chk("shift_offset_hi", bus.shift_offset[95:64], 32'h9);
    @(posedge clk); #1;
    chk("weight_update_single", bus.weight_update, 0);

    // Compute: activation then psum, result after 2 cycles, then backpressure
    bus.result_in = 128'hA5;
    aflat = '0;
    for (int i = 0; i < 4; i++) aflat[64*i +: 64] = {$urandom, $urandom};
    aq.push_back(aflat);
    for (int i = 0; i < 4; i++) send(2'd1, aflat[64*i +: 64]);
    chk("activation_update_pulse", bus.activation_update, 1);
    chk("activation_out", bus.activation_out, aflat);
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    p_last = {p1, p0};
    pq.push_back(p_last);
    rq.push_back(128'hA5);
    send(2'd2, p0);
    send(2'd2, p1);
    chk("psum_update_pulse", bus.psum_update, 1);
    chk("psum_in_ready_blocked", bus.in_ready, 0);
    chk("psum_out", bus.psum_out, p_last);
    @(posedge clk); #1;
    chk("psum_update_single", bus.psum_update, 0);
    chk("res_valid_lat1", bus.res_valid, 0);
    chk("wait_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("res_valid_lat2", bus.res_valid, 1);
    chk("res_data_a5", bus.res_data, 128'hA5);
    bus.result_in = 128'h5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_data", bus.res_data, 128'hA5);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("bp_release_res_valid", bus.res_valid, 0);
    chk("bp_release_in_ready", bus.in_ready, 1);

    // Minimum gap: res_ready already high when the result appears
    rv = {$urandom, $urandom, $urandom, $urandom};
    bus.result_in = rv;
    bus.res_ready = 1'b1;
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    p_last = {p1, p0};
    pq.push_back(p_last);
    rq.push_back(rv);
    send(2'd2, p0);
    send(2'd2, p1);
    chk("gap_psum_update", bus.psum_update, 1);
    @(posedge clk); #1;
    chk("gap_res_valid_early", bus.res_valid, 0);
    @(posedge clk); #1;
    chk("gap_res_valid", bus.res_valid, 1);
    chk("gap_res_data", bus.res_data, rv);
    @(posedge clk); #1;
    chk("gap_res_valid_clear", bus.res_valid, 0);
    chk("gap_in_ready", bus.in_ready, 1);
    bus.res_ready = 1'b0;

    // Abort: 2 activation beats, then a weight bundle
    send(2'd1, {$urandom, $urandom});
    send(2'd1, {$urandom, $urandom});
    wflat = '0;
    for (int i = 0; i < 10; i++) begin
      beat_v = {$urandom, $urandom};
      if (i < 9) wflat[64*i +: 64] = beat_v;
      else wflat[607:576] = beat_v[31:0];
      if (i == 0) begin
        abort_pending++;
        wq.push_back(wflat);
      end
      send(2'd0, beat_v);
      if (i == 0) begin
        chk("abort_pulse", bus.err_abort, 1);
        chk("abort_activation_held", bus.activation_out, aflat);
        chk("abort_no_act_strobe", bus.activation_update, 0);
      end
      if (i == 1) chk("abort_single", bus.err_abort, 0);
    end
    wq[wq.size()-1] = wflat;
    chk("abort_weight_update", bus.weight_update, 1);
    chk("abort_weight_sign", bus.weight_sign, wflat[319:256]);

    // Psum-zero beat
`ifdef OCTET_PSUM_ZERO_EN
    rv = {$urandom, $urandom, $urandom, $urandom};
    bus.result_in = rv;
    bus.res_ready = 1'b1;
    pq.push_back('0);
    rq.push_back(rv);
    send(2'd3, {$urandom, $urandom});
    chk("pz_psum_update", bus.psum_update, 1);
    chk("pz_psum_out", bus.psum_out, 0);
    chk("pz_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pz_res_valid", bus.res_valid, 1);
    chk("pz_res_data", bus.res_data, rv);
    @(posedge clk); #1;
    chk("pz_in_ready_after", bus.in_ready, 1);
    bus.res_ready = 1'b0;
    p_last = '0;
`else
    abort_pending++;
    send(2'd3, {$urandom, $urandom});
    chk("k3_err_abort", bus.err_abort, 1);
    chk("k3_no_psum_update", bus.psum_update, 0);
    chk("k3_psum_held", bus.psum_out, p_last);
    chk("k3_in_ready", bus.in_ready, 1);
    send(2'd0, {$urandom, $urandom});
    abort_pending++;
    send(2'd3, {$urandom, $urandom});
    chk("k3_partial_abort", bus.err_abort, 1);
    wflat = '0;
    for (int i = 0; i < 9; i++) wflat[64*i +: 64] = {$urandom, $urandom};
    wflat[607:576] = $urandom;
    wq.push_back(wflat);
    for (int i = 0; i < 10; i++) begin
      send(2'd0, (i < 9) ? wflat[64*i +: 64] : {32'hDEAD_BEEF, wflat[607:576]});
      if (i == 0) chk("k3_abort_single", bus.err_abort, 0);
      if (i == 8) chk("k3_discard_no_early", bus.weight_update, 0);
    end
    chk("k3_weight_update", bus.weight_update, 1);
`endif

    // Reset one cycle after psum_update: result is lost
    bus.result_in = {$urandom, $urandom, $urandom, $urandom};
    bus.res_ready = 1'b1;
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    pq.push_back({p1, p0});
    send(2'd2, p0);
    send(2'd2, p1);
    chk("rw_psum_update", bus.psum_update, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rw_res_valid_in_rst", bus.res_valid, 0);
    chk("rw_in_ready_in_rst", bus.in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rw_res_valid", bus.res_valid, 0);
    end
    chk("rw_in_ready", bus.in_ready, 1);
    chk("rw_psum_zero", bus.psum_out, 0);
    chk("rw_weight_zero", bus.weight_data, 0);
    chk("rw_activation_zero", bus.activation_out, 0);
    chk("rw_shift_zero", bus.shift_offset, 0);
    bus.res_ready = 1'b0;

    // Reset mid-bundle: the partial activation bundle is forgotten
    send(2'd1, {$urandom, $urandom});
    send(2'd1, {$urandom, $urandom});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    aflat = '0;
    for (int i = 0; i < 4; i++) aflat[64*i +: 64] = {$urandom, $urandom};
    aq.push_back(aflat);
    for (int i = 0; i < 4; i++) begin
      send(2'd1, aflat[64*i +: 64]);
      if (i == 0) chk("rm_no_abort", bus.err_abort, 0);
      if (i == 1) chk("rm_no_early_update", bus.activation_update, 0);
    end
    chk("rm_activation_update", bus.activation_update, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_weight_empty", wq.size(), 0);
    chk("sb_activation_empty", aq.size(), 0);
    chk("sb_psum_empty", pq.size(), 0);
    chk("sb_result_empty", rq.size(), 0);
    chk("sb_abort_all_seen", abort_pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/octet_loader.md
# octet_loader

Stream-to-array sequencer that feeds one bOctet compute unit and drains its results. It accepts 64-bit typed beats on a valid/ready input and assembles them into weight, activation and partial-sum bundles. It drives the bOctet update strobes and held operand buses, waits a fixed compute latency, then captures the 128-bit result into a valid/ready output. It sits between the on-chip buffer DMA and the bOctet instance.

## Interface
- RESULT_LAT, 2: cycles from the psum_update pulse to the result sample; legal range 1..15.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_kind  in  2  beat type: 0 = weight, 1 = activation, 2 = psum, 3 = psum-zero (see Configuration).
- in_data  in  64  beat payload.
- weight_data / weight_sign / weight_sel_level0 / weight_sel_level1 / shift_offset  out  256/64/64/128/96  held weight bundle.
- activation_out  out  256  held activation bundle.
- psum_out  out  128  held partial sums.
- weight_update / activation_update / psum_update  out  1  single-cycle load strobes to bOctet.
- result_in  in  128  bOctet result_out.
- res_valid  out  1  captured result valid.
- res_ready  in  1  downstream accept.
- res_data  out  128  captured result.
- err_abort  out  1  one-cycle pulse when a partial bundle is discarded.

## Operation
- States: LOAD, WAIT, HOLD. Reset enters LOAD with beat_cnt=0.
- LOAD: in_ready=1. Each accepted beat is written to slot beat_cnt of the shadow register of its kind, and beat_cnt increments.
- Bundle lengths:
  - weight: 10 beats. The packing is {shift_offset, sel_level1, sel_level0, sign, data}, with beat i at bits [64i+63:64i]. Bits [63:32] of beat 9 are ignored.
  - activation: 4 beats, beat i at activation[64i+63:64i].
  - psum: 2 beats, beat 0 at psum[63:0].
- Bundle complete: the shadow register is copied to the output bus and the matching update strobe is asserted for exactly one cycle. beat_cnt then returns to 0.
  - weight and activation completions stay in LOAD.
  - psum completion goes to WAIT, with the latency counter loaded to RESULT_LAT.
- Kind change with beat_cnt≠0: the partial bundle is discarded, err_abort pulses, and the new beat becomes beat 0 of its own kind. Output buses are unchanged.
- WAIT: in_ready=0. The counter decrements each cycle. At count 1, result_in is registered into res_data, res_valid is set, and the state goes to HOLD.
- HOLD: in_ready=0. On res_valid && res_ready, res_valid clears and the state goes to LOAD.
- Output buses change only on bundle completion, so bOctet always sees stable operands.

## Timing
- Reset values: all buses 0, all strobes 0, res_valid=0, err_abort=0, in_ready=1.
- Last beat of a bundle accepted at edge N: the bus updates and the strobe is high during cycle N..N+1. bOctet captures at edge N+1.
- psum_update high in cycle C: result_in is sampled at edge C+RESULT_LAT, and res_valid is high from that edge.
- Minimum result-to-next-beat gap: res_ready high on the first res_valid cycle gives in_ready=1 in the next cycle.
- Reset mid-bundle or in WAIT/HOLD: the partial bundle and any pending result are lost, and no strobe is issued.
- Weight/activation strobes may fire in the same cycle that the prior psum strobe has fired? No: psum completion blocks input, so at most one strobe is asserted per cycle.

## Configuration
- OCTET_PSUM_ZERO_EN defined: a single kind-3 beat clears psum_out to 0, pulses psum_update and enters WAIT, exactly as a completed psum bundle does. Its payload is ignored.
- Not defined: a kind-3 beat is accepted and dropped, and err_abort pulses. If a partial bundle was pending, it is discarded with the same single err_abort pulse.

## Test plan
- Weight load: 10 weight beats with in_data=i replicated (64'h0000_0000_0000_000i) → one weight_update pulse. weight_data[63:0]=0, sign=64'h4, shift_offset[31:0]=32'h8, shift_offset[95:64]=32'h9.
- Compute: 4 activation beats, then 2 psum beats, with RESULT_LAT=2 and result_in driven 128'hA5 → activation_update pulse, then psum_update pulse. res_valid rises exactly 2 cycles after psum_update with res_data=128'hA5, and in_ready=0 until the handshake.
- Backpressure: res_ready held low for 5 cycles → res_valid and res_data stable, in_ready=0. Raising res_ready → LOAD the next cycle.
- Abort: 2 activation beats, then a weight beat → err_abort pulse, activation_out unchanged, and 9 further weight beats complete the weight bundle.
- Psum-zero: kind-3 beat → with the macro, psum_out=0, psum_update pulses and res_valid follows. Without the macro, err_abort pulses only.
- Reset in WAIT: assert rst 1 cycle after psum_update → res_valid stays 0, all buses 0, in_ready=1 after release.
